// File: rtl/ps2_pkg.sv
// Shared constants and frame-check helper for the PS/2 receive controller.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } ps2_state_e;

  localparam int   FRAME_BITS  = 11;
  localparam int   DATA_BITS   = 8;
  localparam int   SAMPLE_BITS = FRAME_BITS - 1;  // start bit is consumed by IDLE
  localparam int   CNT_W       = 4;
  localparam logic BUS_IDLE    = 1'b1;

  // Samples are {stop, parity, data[7:0]}; odd parity over data+parity.
  function automatic logic frame_good(input logic [SAMPLE_BITS-1:0] s);
    return (^s[DATA_BITS:0]) && s[SAMPLE_BITS-1];
  endfunction

endpackage

// File: rtl/ps2_rx_ctrl_if.sv
// Scan-code handshake between the PS/2 receiver (master) and the kb decoder (slave).
interface ps2_rx_ctrl_if;
  logic [7:0] code;
  logic       code_valid;
  logic       code_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output code, code_valid, frame_err, overrun, busy,
    input  code_ack
  );

  modport slave (
    input  code, code_valid, frame_err, overrun, busy,
    output code_ack
  );
endinterface

// File: rtl/ps2_sync.sv
// Multi-flop synchronizer for the raw PS/2 pins plus ps2_clk falling-edge detect.
module ps2_sync
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;

  // Flops preset to the idle bus level so reset never fabricates a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= {SYNC_STAGES{BUS_IDLE}};
      data_sync <= {SYNC_STAGES{BUS_IDLE}};
      clk_prev  <= BUS_IDLE;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 frame sequencer: start, 8 data LSB-first, odd parity, stop -> valid/ack scan code.
// Optional mid-frame watchdog enabled by defining PS2_WATCHDOG_EN.
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_rx_ctrl_if.master  bus
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("ps2_rx_ctrl: SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("ps2_rx_ctrl: TIMEOUT_CYC must be at least 2");
  end

  logic data_s;
  logic fall;

  ps2_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data_s   (data_s),
    .fall     (fall)
  );

  ps2_state_e             state;
  logic [CNT_W-1:0]       cnt;
  logic [SAMPLE_BITS-1:0] samples;
  logic [DATA_BITS-1:0]   code_r;
  logic                   valid_r;
  logic                   err_r;
  logic                   ovr_r;
  logic                   busy_r;

`ifdef PS2_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  logic [WD_W-1:0] wd;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      samples <= '0;
      code_r  <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      ovr_r   <= 1'b0;
      busy_r  <= 1'b0;
`ifdef PS2_WATCHDOG_EN
      wd      <= '0;
`endif
    end else begin
      err_r <= 1'b0;

      // Ack is honoured only against a held byte; CHECK below may reload it.
      if (valid_r && bus.code_ack) begin
        valid_r <= 1'b0;
        ovr_r   <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (fall && !data_s) begin
            state  <= ST_SHIFT;
            cnt    <= '0;
            busy_r <= 1'b1;
`ifdef PS2_WATCHDOG_EN
            wd     <= '0;
`endif
          end
        end

        ST_SHIFT: begin
          if (fall) begin
            samples[cnt] <= data_s;
            cnt          <= cnt + 4'd1;
`ifdef PS2_WATCHDOG_EN
            wd           <= '0;
`endif
            if (cnt == 4'(SAMPLE_BITS - 1)) begin
              state <= ST_CHECK;
            end
          end
`ifdef PS2_WATCHDOG_EN
          else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_r <= 1'b0;
            err_r  <= 1'b1;
            wd     <= '0;
          end else begin
            wd <= wd + 1'b1;
          end
`endif
        end

        ST_CHECK: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
          if (frame_good(samples)) begin
            if (!valid_r || bus.code_ack) begin
              code_r  <= samples[DATA_BITS-1:0];
              valid_r <= 1'b1;
            end else begin
              ovr_r <= 1'b1;
            end
          end else begin
            err_r <= 1'b1;
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.code       = code_r;
  assign bus.code_valid = valid_r;
  assign bus.frame_err  = err_r;
  assign bus.overrun    = ovr_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Bench for ps2_rx_ctrl: table of frames plus hand sequences for reset, glitch and timeout.
module tb_ps2_rx_ctrl;
  import ps2_pkg::*;

  localparam int SYNC = 2;
  localparam int TMO  = 100;
  localparam int HALF = 6;
  localparam int LAT  = SYNC + 2;

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk;
  logic ps2_data;

  ps2_rx_ctrl_if bus ();

  ps2_rx_ctrl #(
    .SYNC_STAGES (SYNC),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       stop;
    logic       ack_chk;
    logic       exp_valid;
    logic [7:0] exp_code;
    logic       exp_err;
    logic       exp_ovr;
    logic       exp_rise;
    logic       ack_after;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk); ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_head(input logic [7:0] d, input logic par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
  endtask

  // Stop bit with per-cycle observation after its falling edge.
  task automatic send_stop(input logic stop, input logic ack_chk,
                           output logic [LAT+1:0] vh, output logic [LAT+1:0] eh,
                           output logic [7:0] code_at, output logic ovr_at);
    vh = '0; eh = '0; code_at = '0; ovr_at = 1'b0;
    @(negedge clk); ps2_data = stop;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 1; i <= LAT + 1; i++) begin
      @(posedge clk); #1;
      vh[i] = bus.code_valid;
      eh[i] = bus.frame_err;
      if (i == LAT) begin
        code_at = bus.code;
        ovr_at  = bus.overrun;
        bus.code_ack = 1'b0;
      end
      if (ack_chk && i == LAT - 1) bus.code_ack = 1'b1;
    end
    @(negedge clk); ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic sb_pop(input string name);
    logic [7:0] e;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: got code %0h with empty scoreboard", name, bus.code);
    end else begin
      e = sb_q.pop_front();
      chk(name, bus.code, e);
    end
  endtask

  task automatic do_ack();
    @(negedge clk); bus.code_ack = 1'b1;
    @(posedge clk); #1;
    chk("ack_valid_drop", bus.code_valid, 1'b0);
    chk("ack_ovr_clear", bus.overrun, 1'b0);
    @(negedge clk); bus.code_ack = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    logic [LAT+1:0] vh, eh;
    logic [7:0] code_at;
    logic ovr_at, seen_err, seen_busy;
    int cyc;

    vecs[0] = '{8'h1C, 0, 1, 0, 1, 8'h1C, 0, 0, 1, 0};
    vecs[1] = '{8'h32, 0, 1, 0, 1, 8'h1C, 0, 1, 0, 1};
    vecs[2] = '{8'hF0, 1, 1, 0, 0, 8'h1C, 1, 0, 0, 0};
    vecs[3] = '{8'hA5, 0, 0, 0, 0, 8'h1C, 1, 0, 0, 0};
    vecs[4] = '{8'h00, 0, 1, 0, 1, 8'h00, 0, 0, 1, 0};
    vecs[5] = '{8'h5A, 0, 1, 1, 1, 8'h5A, 0, 0, 0, 1};
    vecs[6] = '{8'hFF, 0, 1, 0, 1, 8'hFF, 0, 0, 1, 1};

    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; bus.code_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_code", bus.code, 8'h00);
    chk("rst_valid", bus.code_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_err", bus.frame_err, 1'b0);
    chk("rst_ovr", bus.overrun, 1'b0);
    @(negedge clk); reset = 1'b0;

    // Ack with nothing held is ignored.
    @(negedge clk); bus.code_ack = 1'b1;
    @(posedge clk); #1;
    chk("idle_ack_valid", bus.code_valid, 1'b0);
    chk("idle_ack_err", bus.frame_err, 1'b0);
    @(negedge clk); bus.code_ack = 1'b0;

    // Glitch: falling edge with data high must not start a frame.
    @(negedge clk); ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    seen_err = 1'b0; seen_busy = 1'b0;
    for (int i = 0; i < 2 * HALF; i++) begin
      @(posedge clk); #1;
      seen_err  |= bus.frame_err;
      seen_busy |= bus.busy;
    end
    @(negedge clk); ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    chk("glitch_busy", seen_busy, 1'b0);
    chk("glitch_err", seen_err, 1'b0);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].exp_rise || vecs[v].ack_chk) sb_q.push_back(vecs[v].data);
      send_head(vecs[v].data, (~^vecs[v].data) ^ vecs[v].bad_par);
      send_stop(vecs[v].stop, vecs[v].ack_chk, vh, eh, code_at, ovr_at);
      chk($sformatf("v%0d_valid", v), vh[LAT], vecs[v].exp_valid);
      chk($sformatf("v%0d_code", v), code_at, vecs[v].exp_code);
      chk($sformatf("v%0d_err", v), eh[LAT], vecs[v].exp_err);
      chk($sformatf("v%0d_err_pulse", v), eh[LAT+1], 1'b0);
      chk($sformatf("v%0d_ovr", v), ovr_at, vecs[v].exp_ovr);
      if (vecs[v].exp_rise) chk($sformatf("v%0d_latency", v), vh[LAT-1], 1'b0);
      if (vecs[v].exp_rise || vecs[v].ack_chk) sb_pop($sformatf("v%0d_sb", v));
      if (vecs[v].ack_after) do_ack();
    end

    // Reset mid-frame while a byte is held, then a clean frame.
    sb_q.push_back(8'h1C);
    send_head(8'h1C, 1'b0);
    send_stop(1'b1, 1'b0, vh, eh, code_at, ovr_at);
    chk("pre_rst_valid", vh[LAT], 1'b1);
    sb_pop("pre_rst_sb");
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'(8'h1C >> i));
    @(posedge clk); #1;
    chk("mid_busy", bus.busy, 1'b1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async_rst_busy", bus.busy, 1'b0);
    chk("async_rst_valid", bus.code_valid, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    sb_q.push_back(8'h1C);
    send_head(8'h1C, 1'b0);
    send_stop(1'b1, 1'b0, vh, eh, code_at, ovr_at);
    chk("post_rst_valid", vh[LAT], 1'b1);
    chk("post_rst_lat", vh[LAT-1], 1'b0);
    sb_pop("post_rst_sb");
    do_ack();

    // Stall ps2_clk after five bits.
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'(8'h1C >> i));
    @(negedge clk); ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    cyc = 0; seen_err = 1'b0;
    while (cyc < 300 && !seen_err) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == HALF) ps2_clk = 1'b1;
      seen_err = bus.frame_err;
    end
`ifdef PS2_WATCHDOG_EN
    chk("wd_err_seen", seen_err, 1'b1);
    chk("wd_latency", cyc, TMO + SYNC + 1);
    chk("wd_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    chk("wd_err_pulse", bus.frame_err, 1'b0);
`else
    chk("nowd_err", seen_err, 1'b0);
    chk("nowd_busy", bus.busy, 1'b1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1;
    chk("nowd_rst_busy", bus.busy, 1'b0);
`endif

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
